imem_loader: RTL

//   Byte-stream writer for the CPU instruction memory. It fills the memory that the PC reads.
//   - Accepts a length-prefixed byte stream over a valid/ready handshake.
//   - Packs each 4 bytes into one 32-bit instruction and writes it to successive imem addresses from 0.
//   - Holds the core (PC, regfile, zf) in reset while loading and releases it on successful completion.

---
 rtl/imem_loader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// imem_loader: length-prefixed byte stream -> 32-bit instruction memory writes; holds the core in reset while loading.
// Optional trailing checksum byte (CHECK/ERR states) enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned WORD_W    = 32,
  parameter bit          BOOT_HOLD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERR} state_t;

  localparam int unsigned MAX_IDX = (1 << ADDR_W) - 1;

  state_t            state, state_d;
  logic [ADDR_W-1:0] idx, idx_d;
  logic [ADDR_W-1:0] last_idx, last_idx_d;
  logic [ADDR_W-1:0] addr_d;
  logic [1:0]        byte_cnt, byte_cnt_d;
  logic [WORD_W-1:0] shreg, shreg_d;
  logic [WORD_W-1:0] wdata_d;
  logic [7:0]        n_m1;
  logic              xfer;
  logic              rx_ready_d, we_d, busy_d, done_d, core_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum, sum_d;
  logic              err_d;
`endif

  assign xfer = rx_valid & rx_ready;
  // N=0 wraps to 255 here, so one clamp covers both the 256-word case and narrow memories.
  assign n_m1 = rx_data - 8'd1;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d    = state;
    idx_d      = idx;
    last_idx_d = last_idx;
    byte_cnt_d = byte_cnt;
    shreg_d    = shreg;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d      = sum;
`endif

    case (state)
      IDLE, DONE, ERR: begin
        if (load_start) begin
          state_d    = COUNT;
          idx_d      = '0;
          byte_cnt_d = '0;
          shreg_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end
      COUNT: begin
        if (xfer) begin
          last_idx_d = (32'(n_m1) > MAX_IDX) ? ADDR_W'(MAX_IDX) : ADDR_W'(n_m1);
          state_d    = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          shreg_d    = {shreg[WORD_W-9:0], rx_data};
          byte_cnt_d = byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = sum + rx_data;
`endif
          if (byte_cnt == 2'd3) begin
            state_d = WRITE;
            addr_d  = idx;
            wdata_d = {shreg[WORD_W-9:0], rx_data};
          end
        end
      end
      WRITE: begin
        // The index saturates at the last word instead of wrapping back to 0.
        if (idx == last_idx) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          idx_d   = idx + ADDR_W'(1);
          state_d = DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (xfer) state_d = (rx_data == sum) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase

    rx_ready_d = (state_d == COUNT) || (state_d == DATA) || (state_d == CHECK);
    busy_d     = rx_ready_d || (state_d == WRITE);
    we_d       = (state_d == WRITE);
    done_d     = (state_d == DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    err_d      = (state_d == ERR);
`endif

    // Core reset: low throughout a load, high only after success; ERR keeps it low.
    core_rst_n_d = core_rst_n;
    if (busy_d)                core_rst_n_d = 1'b0;
    else if (state_d == DONE)  core_rst_n_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      last_idx   <= '0;
      byte_cnt   <= '0;
      shreg      <= '0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      core_rst_n <= ~BOOT_HOLD;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      last_idx   <= last_idx_d;
      byte_cnt   <= byte_cnt_d;
      shreg      <= shreg_d;
      rx_ready   <= rx_ready_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      busy       <= busy_d;
      done       <= done_d;
      core_rst_n <= core_rst_n_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      err <= 1'b0;
    end else begin
      sum <= sum_d;
      err <= err_d;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
